// File: rtl/pcileech_ft601_emu_if.sv
// pcileech_ft601_emu_if: FT601 pad signals plus host stream, error and counter signals of the FT601 device model
// master: FPGA/host side driving strobes, write data and host streams; slave: the device model
interface pcileech_ft601_emu_if;
  logic [31:0] ft601_data_i;
  logic [31:0] ft601_data_o;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be_i;
  logic [3:0]  ft601_be_o;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_oe_n;
  logic        ft601_rd_n;
  logic        ft601_wr_n;
  logic [31:0] s_din;
  logic        s_valid;
  logic        s_ready;
  logic [35:0] m_dout;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  err;
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
  modport master (
    output ft601_data_i, ft601_be_i, ft601_oe_n, ft601_rd_n, ft601_wr_n, s_din, s_valid, m_ready,
    input  ft601_data_o, ft601_data_oe, ft601_be_o, ft601_rxf_n, ft601_txe_n, s_ready, m_dout, m_valid, err, cnt_rd, cnt_wr
  );
  modport slave (
    input  ft601_data_i, ft601_be_i, ft601_oe_n, ft601_rd_n, ft601_wr_n, s_din, s_valid, m_ready,
    output ft601_data_o, ft601_data_oe, ft601_be_o, ft601_rxf_n, ft601_txe_n, s_ready, m_dout, m_valid, err, cnt_rd, cnt_wr
  );
endinterface

// File: rtl/pcileech_ft601_emu.sv
// pcileech_ft601_emu: device-side FT601 245-sync FIFO bus model with FWFT RX/TX FIFOs and sticky protocol error flags
// Ports: clk (bus clock), rst_n (sync active-low reset), bus (slave modport: FT601 pads, s_ host->FPGA stream, m_ FPGA->host stream, err, cnt_rd, cnt_wr)
// Optional: define PCILEECH_FT601_EMU_THROTTLE_EN to force rxf_n/txe_n high on LFSR-selected cycles
module pcileech_ft601_emu #(
  parameter int          RX_DEPTH_LOG2 = 9,
  parameter int          TX_DEPTH_LOG2 = 9,
  parameter logic [15:0] THROTTLE_SEED = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst_n,
  pcileech_ft601_emu_if.slave bus
);
  typedef enum logic [1:0] {R_IDLE, R_OE, R_DATA} rstate_t;
  rstate_t r_state, w_state_n;
  logic [31:0] r_rx_mem [1<<RX_DEPTH_LOG2];
  logic [35:0] r_tx_mem [1<<TX_DEPTH_LOG2];
  logic [RX_DEPTH_LOG2:0] r_rx_wp, r_rx_rp, w_rx_wp_n, w_rx_rp_n;
  logic [TX_DEPTH_LOG2:0] r_tx_wp, r_tx_rp, w_tx_wp_n, w_tx_rp_n;
  logic r_rxf_n, r_txe_n, r_s_ready, r_m_valid, r_data_oe, w_thr, w_rxf_n, w_txe_n;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic [2:0] r_err;
  logic [31:0] r_cnt_rd, r_cnt_wr;
`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= !rst_n ? THROTTLE_SEED : {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0);
  assign w_thr = r_lfsr[1:0] == 2'b00;
`else
  assign w_thr = &{1'b0, THROTTLE_SEED};
`endif
  assign w_rxf_n = r_rxf_n | w_thr;
  assign w_txe_n = r_txe_n | w_thr;
  assign w_rx_push = bus.s_valid & r_s_ready;
  assign w_rx_pop = (r_state != R_IDLE) & !bus.ft601_rd_n & !bus.ft601_oe_n & !w_rxf_n;
  assign w_tx_push = !bus.ft601_wr_n & !w_txe_n;
  assign w_tx_pop = r_m_valid & bus.m_ready;
  assign w_rx_wp_n = r_rx_wp + {{RX_DEPTH_LOG2{1'b0}}, w_rx_push};
  assign w_rx_rp_n = r_rx_rp + {{RX_DEPTH_LOG2{1'b0}}, w_rx_pop};
  assign w_tx_wp_n = r_tx_wp + {{TX_DEPTH_LOG2{1'b0}}, w_tx_push};
  assign w_tx_rp_n = r_tx_rp + {{TX_DEPTH_LOG2{1'b0}}, w_tx_pop};
  assign bus.ft601_data_o = (r_rx_wp == r_rx_rp) ? 32'h0 : r_rx_mem[r_rx_rp[RX_DEPTH_LOG2-1:0]];
  assign bus.ft601_data_oe = r_data_oe;
  assign bus.ft601_be_o = 4'hF;
  assign bus.ft601_rxf_n = w_rxf_n;
  assign bus.ft601_txe_n = w_txe_n;
  assign bus.s_ready = r_s_ready;
  assign bus.m_dout = r_tx_mem[r_tx_rp[TX_DEPTH_LOG2-1:0]];
  assign bus.m_valid = r_m_valid;
  assign bus.err = r_err;
  assign bus.cnt_rd = r_cnt_rd;
  assign bus.cnt_wr = r_cnt_wr;
  always_comb
    w_state_n = bus.ft601_oe_n ? R_IDLE :
                r_state == R_IDLE ? (w_rxf_n ? R_IDLE : R_OE) :
                r_state == R_OE ? (bus.ft601_rd_n ? R_OE : R_DATA) : r_state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rxf_n <= 1'b1;
      r_txe_n <= 1'b1;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_data_oe <= 1'b0;
      r_err <= 3'b000;
      r_cnt_rd <= '0;
      r_cnt_wr <= '0;
    end else begin
      r_state <= w_state_n;
      r_rx_wp <= w_rx_wp_n;
      r_rx_rp <= w_rx_rp_n;
      r_tx_wp <= w_tx_wp_n;
      r_tx_rp <= w_tx_rp_n;
      r_rxf_n <= w_rx_wp_n == w_rx_rp_n;
      r_s_ready <= (w_rx_wp_n ^ w_rx_rp_n) != {1'b1, {RX_DEPTH_LOG2{1'b0}}};
      r_txe_n <= (w_tx_wp_n ^ w_tx_rp_n) == {1'b1, {TX_DEPTH_LOG2{1'b0}}};
      r_m_valid <= w_tx_wp_n != w_tx_rp_n;
      r_data_oe <= !bus.ft601_oe_n;
      r_err <= r_err | {!bus.ft601_oe_n & !bus.ft601_wr_n, !bus.ft601_wr_n & w_txe_n, !bus.ft601_rd_n & (r_state == R_IDLE)};
      r_cnt_rd <= r_cnt_rd + {31'd0, w_rx_pop};
      r_cnt_wr <= r_cnt_wr + {31'd0, w_tx_push};
    end
  end
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[RX_DEPTH_LOG2-1:0]] <= bus.s_din;
    if (w_tx_push) r_tx_mem[r_tx_wp[TX_DEPTH_LOG2-1:0]] <= {bus.ft601_be_i, bus.ft601_data_i};
  end
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// tb_pcileech_ft601_emu: scoreboard bench for the FT601 device model with 16-deep FIFOs
module tb_pcileech_ft601_emu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] rx_q[$];
  logic [35:0] tx_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  always #5 clk = ~clk;
  pcileech_ft601_emu_if bus();
  pcileech_ft601_emu #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .THROTTLE_SEED(16'hACE1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic tick;
    @(posedge clk);
    #1;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
  endtask
  task automatic idle;
    bus.ft601_data_i = '0;
    bus.ft601_be_i = '0;
    bus.ft601_oe_n = 1'b1;
    bus.ft601_rd_n = 1'b1;
    bus.ft601_wr_n = 1'b1;
    bus.s_din = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
  endtask
  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    rx_q.delete();
    tx_q.delete();
  endtask
  task automatic host_push(input logic [31:0] base, input int cnt);
    int n = 0;
    int g = 0;
    while (n < cnt && g < 100) begin
      bus.s_valid = bus.s_ready;
      bus.s_din = base + 32'(n);
      if (bus.s_ready) begin
        rx_q.push_back(base + 32'(n));
        n++;
      end
      tick();
      g++;
    end
    bus.s_valid = 1'b0;
  endtask
  task automatic fpga_write(input logic [31:0] base, input int cnt);
    int n = 0;
    int g = 0;
    while (n < cnt && g < 200) begin
      bus.ft601_wr_n = bus.ft601_txe_n;
      bus.ft601_data_i = base + 32'(n);
      bus.ft601_be_i = 4'(15 - n);
      if (!bus.ft601_txe_n) begin
        tx_q.push_back({bus.ft601_be_i, bus.ft601_data_i});
        n++;
      end
      tick();
      g++;
    end
    bus.ft601_wr_n = 1'b1;
  endtask
  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    bus.ft601_oe_n = 1'b0;
    bus.ft601_rd_n = 1'b0;
    bus.ft601_wr_n = 1'b0;
    repeat (4) tick();
    tests++; if (bus.ft601_rxf_n !== 1'b1) begin fails++; $display("FAIL reset_rxf_n got %b exp 1", bus.ft601_rxf_n); end
    tests++; if (bus.ft601_txe_n !== 1'b1) begin fails++; $display("FAIL reset_txe_n got %b exp 1", bus.ft601_txe_n); end
    tests++; if (bus.ft601_data_oe !== 1'b0) begin fails++; $display("FAIL reset_data_oe got %b exp 0", bus.ft601_data_oe); end
    tests++; if (bus.err !== 3'b000) begin fails++; $display("FAIL reset_err got %b exp 000", bus.err); end
    tests++; if (bus.cnt_rd !== 32'd0) begin fails++; $display("FAIL reset_cnt_rd got %0d exp 0", bus.cnt_rd); end
    tests++; if (bus.cnt_wr !== 32'd0) begin fails++; $display("FAIL reset_cnt_wr got %0d exp 0", bus.cnt_wr); end
    tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %b exp 0", bus.s_ready); end
    tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
    tests++; if (bus.ft601_data_o !== 32'h0) begin fails++; $display("FAIL reset_data_o got %h exp 0", bus.ft601_data_o); end
    tests++; if (bus.ft601_be_o !== 4'hF) begin fails++; $display("FAIL reset_be_o got %h exp F", bus.ft601_be_o); end
    idle();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready got %b exp 1", bus.s_ready); end
  endtask
  task automatic test_read_burst;
    int g = 0;
    logic armed = 1'b0;
    do_reset();
    host_push(32'h1000, 8);
    bus.ft601_oe_n = 1'b0;
    while (rx_q.size() > 0 && g < 200) begin
      bus.ft601_rd_n = !(armed && !bus.ft601_rxf_n);
      if (!bus.ft601_rd_n) begin
        tests++;
        if (bus.ft601_data_o !== rx_q[0]) begin fails++; $display("FAIL read_burst_data got %h exp %h", bus.ft601_data_o, rx_q[0]); end
        void'(rx_q.pop_front());
      end
      armed = armed | !bus.ft601_rxf_n;
      tick();
      g++;
    end
    bus.ft601_rd_n = 1'b1;
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL read_burst_timeout left %0d exp 0", rx_q.size()); end
    tests++; if (bus.ft601_rxf_n !== 1'b1) begin fails++; $display("FAIL read_burst_rxf_n got %b exp 1", bus.ft601_rxf_n); end
    tests++; if (bus.cnt_rd !== 32'd8) begin fails++; $display("FAIL read_burst_cnt_rd got %0d exp 8", bus.cnt_rd); end
    tests++; if (bus.ft601_data_oe !== 1'b1) begin fails++; $display("FAIL read_burst_oe_on got %b exp 1", bus.ft601_data_oe); end
    bus.ft601_oe_n = 1'b1;
    tick();
    tests++; if (bus.ft601_data_oe !== 1'b0) begin fails++; $display("FAIL read_burst_oe_off got %b exp 0", bus.ft601_data_oe); end
    tests++; if (bus.err !== 3'b000) begin fails++; $display("FAIL read_burst_err got %b exp 000", bus.err); end
  endtask
  task automatic test_write_full;
    int g = 0;
    do_reset();
    fpga_write(32'h2000, 16);
    tests++; if (bus.ft601_txe_n !== 1'b1) begin fails++; $display("FAIL write_full_txe_n got %b exp 1", bus.ft601_txe_n); end
    tests++; if (bus.cnt_wr !== 32'd16) begin fails++; $display("FAIL write_full_cnt_wr got %0d exp 16", bus.cnt_wr); end
    tests++; if (bus.err !== 3'b000) begin fails++; $display("FAIL write_full_err_clean got %b exp 000", bus.err); end
    for (int k = 0; k < 4; k++) begin
      bus.ft601_wr_n = 1'b0;
      bus.ft601_data_i = 32'h2010 + 32'(k);
      tick();
    end
    bus.ft601_wr_n = 1'b1;
    tests++; if (bus.err !== 3'b010) begin fails++; $display("FAIL write_over_err got %b exp 010", bus.err); end
    tests++; if (bus.cnt_wr !== 32'd16) begin fails++; $display("FAIL write_over_cnt_wr got %0d exp 16", bus.cnt_wr); end
    bus.m_ready = 1'b1;
    while (tx_q.size() > 0 && g < 100) begin
      if (bus.m_valid) begin
        tests++;
        if (bus.m_dout !== tx_q[0]) begin fails++; $display("FAIL write_drain_data got %h exp %h", bus.m_dout, tx_q[0]); end
        void'(tx_q.pop_front());
      end
      tick();
      g++;
    end
    bus.m_ready = 1'b0;
    tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL write_drain_timeout left %0d exp 0", tx_q.size()); end
    tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL write_drain_m_valid got %b exp 0", bus.m_valid); end
  endtask
  task automatic test_protocol_error;
    do_reset();
    host_push(32'h3000, 2);
    bus.ft601_rd_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b1;
    tests++; if (bus.err !== 3'b001) begin fails++; $display("FAIL proto_err got %b exp 001", bus.err); end
    tests++; if (bus.cnt_rd !== 32'd0) begin fails++; $display("FAIL proto_cnt_rd got %0d exp 0", bus.cnt_rd); end
    tests++; if (bus.ft601_data_o !== 32'h3000) begin fails++; $display("FAIL proto_head got %h exp 3000", bus.ft601_data_o); end
    tests++; if (bus.ft601_data_oe !== 1'b0) begin fails++; $display("FAIL proto_data_oe got %b exp 0", bus.ft601_data_oe); end
  endtask
  task automatic test_back_to_back;
    int g = 0;
    int w = 0;
    int r = 0;
    logic done = 1'b0;
    do_reset();
    fpga_write(32'h4000, 15);
    while (!done && g < 50) begin
      if (!bus.ft601_txe_n && bus.m_valid) begin
        bus.ft601_wr_n = 1'b0;
        bus.ft601_data_i = 32'h400F;
        bus.ft601_be_i = 4'hA;
        tx_q.push_back({4'hA, 32'h400F});
        bus.m_ready = 1'b1;
        tests++;
        if (bus.m_dout !== tx_q[0]) begin fails++; $display("FAIL simul_pop_data got %h exp %h", bus.m_dout, tx_q[0]); end
        void'(tx_q.pop_front());
        done = 1'b1;
      end
      tick();
      g++;
    end
    bus.ft601_wr_n = 1'b1;
    bus.m_ready = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL simul_timeout got %b exp 1", done); end
    tests++; if (bus.cnt_wr !== 32'd16) begin fails++; $display("FAIL simul_cnt_wr got %0d exp 16", bus.cnt_wr); end
    tests++; if (bus.ft601_txe_n !== 1'b0 && bus.ft601_txe_n !== 1'b1) begin fails++; $display("FAIL simul_txe_n got %b exp 0/1", bus.ft601_txe_n); end
    g = 0;
    bus.m_ready = 1'b1;
    while (tx_q.size() > 0 && g < 100) begin
      if (bus.m_valid) begin
        tests++;
        if (bus.m_dout !== tx_q[0]) begin fails++; $display("FAIL simul_drain_data got %h exp %h", bus.m_dout, tx_q[0]); end
        void'(tx_q.pop_front());
      end
      tick();
      g++;
    end
    tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL simul_occupancy m_valid got %b exp 0 after 15 pops", bus.m_valid); end
    g = 0;
    while (r < 100 && g < 500) begin
      if (w < 100 && !bus.ft601_txe_n) begin
        bus.ft601_wr_n = 1'b0;
        bus.ft601_data_i = 32'h5000 + 32'(w);
        bus.ft601_be_i = 4'(w);
        tx_q.push_back({4'(w), 32'h5000 + 32'(w)});
        w++;
      end else bus.ft601_wr_n = 1'b1;
      if (bus.m_valid) begin
        tests++;
        if (tx_q.size() == 0 || bus.m_dout !== tx_q[0]) begin fails++; $display("FAIL stream_data got %h exp %h", bus.m_dout, tx_q.size() ? tx_q[0] : 36'h0); end
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        r++;
      end
      tick();
      g++;
    end
    bus.ft601_wr_n = 1'b1;
    bus.m_ready = 1'b0;
    tests++; if (r != 100) begin fails++; $display("FAIL stream_count got %0d exp 100", r); end
    tests++; if (bus.cnt_wr !== 32'd116) begin fails++; $display("FAIL stream_cnt_wr got %0d exp 116", bus.cnt_wr); end
    tests++; if (bus.err !== 3'b000) begin fails++; $display("FAIL stream_err got %b exp 000", bus.err); end
  endtask
`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
  task automatic test_throttle;
    int hw = 0;
    int fw = 0;
    logic armed = 1'b0;
    logic rp;
    do_reset();
    bus.m_ready = 1'b1;
    for (int cyc = 0; cyc < 1300; cyc++) begin
      rp = ((cyc / 50) % 2) == 0;
      bus.s_valid = (cyc < 1000) && bus.s_ready;
      bus.s_din = 32'h6000 + 32'(hw);
      if (bus.s_valid) begin
        rx_q.push_back(32'h6000 + 32'(hw));
        hw++;
      end
      if (m_lfsr[1:0] == 2'b00) begin
        tests++;
        if (bus.ft601_rxf_n !== 1'b1 || bus.ft601_txe_n !== 1'b1) begin fails++; $display("FAIL throttle_force rxf_n=%b txe_n=%b exp 1/1", bus.ft601_rxf_n, bus.ft601_txe_n); end
      end
      bus.ft601_oe_n = !rp;
      if (!rp) armed = 1'b0;
      bus.ft601_rd_n = !(rp && armed && !bus.ft601_rxf_n);
      if (!bus.ft601_rd_n) begin
        tests++;
        if (rx_q.size() == 0 || bus.ft601_data_o !== rx_q[0]) begin fails++; $display("FAIL throttle_rx_data got %h exp %h", bus.ft601_data_o, rx_q.size() ? rx_q[0] : 32'h0); end
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      if (rp) armed = armed | !bus.ft601_rxf_n;
      bus.ft601_wr_n = !(!rp && !bus.ft601_txe_n && cyc < 1000);
      bus.ft601_data_i = 32'h7000 + 32'(fw);
      bus.ft601_be_i = 4'hF;
      if (!bus.ft601_wr_n) begin
        tx_q.push_back({4'hF, 32'h7000 + 32'(fw)});
        fw++;
      end
      if (bus.m_valid) begin
        tests++;
        if (tx_q.size() == 0 || bus.m_dout !== tx_q[0]) begin fails++; $display("FAIL throttle_tx_data got %h exp %h", bus.m_dout, tx_q.size() ? tx_q[0] : 36'h0); end
        if (tx_q.size() != 0) void'(tx_q.pop_front());
      end
      tick();
    end
    idle();
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL throttle_rx_loss left %0d exp 0", rx_q.size()); end
    tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL throttle_tx_loss left %0d exp 0", tx_q.size()); end
    tests++; if (bus.err !== 3'b000) begin fails++; $display("FAIL throttle_err got %b exp 000", bus.err); end
    tests++; if (bus.cnt_rd !== 32'(hw)) begin fails++; $display("FAIL throttle_cnt_rd got %0d exp %0d", bus.cnt_rd, hw); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    test_reset();
    test_read_burst();
    test_write_full();
    test_protocol_error();
    test_back_to_back();
`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
    test_throttle();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pcileech_ft601_emu.md
Name: pcileech_ft601_emu

Overview:
- Synthesizable device-side model of the FT601 245-synchronous FIFO bus; the responder to the FPGA-side FT601 initiator in pcileech_com.
- Presents the FT601 pad interface as separate in/out/oe signals and buffers host-to-FPGA and FPGA-to-host words in two internal FIFOs.
- Flags bus-protocol violations.
- Used for on-board loopback builds and as the bus partner in system benches.

Parameters:
- RX_DEPTH_LOG2, 9: log2 depth of host-to-FPGA FIFO (words delivered on the rxf_n/rd_n path).
- TX_DEPTH_LOG2, 9: log2 depth of FPGA-to-host FIFO (words accepted on the txe_n/wr_n path).
- THROTTLE_SEED, 16'hACE1: non-zero LFSR seed, used only with the optional feature.

Ports:
- clk  in  1  FT601 bus clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- ft601_data_i  in  32  bus data driven by the FPGA during writes.
- ft601_data_o  out  32  bus data driven by this model during reads.
- ft601_data_oe  out  1  model drives the bus.
- ft601_be_i  in  4  byte enables from the FPGA.
- ft601_be_o  out  4  byte enables driven during reads; always 4'hF.
- ft601_rxf_n  out  1  low = read data available.
- ft601_txe_n  out  1  low = write space available.
- ft601_oe_n  in  1  FPGA output-enable request.
- ft601_rd_n  in  1  FPGA read strobe.
- ft601_wr_n  in  1  FPGA write strobe.
- s_din  in  32  host word to queue toward the FPGA.
- s_valid  in  1  s_din valid.
- s_ready  out  1  RX FIFO not full.
- m_dout  out  36  {be[3:0], data[31:0]} word written by the FPGA.
- m_valid  out  1  TX FIFO not empty.
- m_ready  in  1  host consumes m_dout.
- err  out  3  sticky errors: [0] rd_n without oe_n, [1] wr_n while txe_n high, [2] oe_n and wr_n both low.
- cnt_rd  out  32  words popped by FPGA reads; wraps.
- cnt_wr  out  32  words pushed by FPGA writes; wraps.

Behaviour:
- Reset while rst_n low at posedge: both FIFOs empty, counters 0, err 0, read FSM R_IDLE, LFSR reloaded.
- Reset output values: rxf_n=1, txe_n=1, data_oe=0, s_ready=0, m_valid=0, data_o=0.
- Reset mid-burst discards FIFO contents; the next cycle obeys reset values regardless of strobes.
- Both FIFOs are first-word-fall-through; data_o and m_dout show the current head.
- Host side uses a valid/ready handshake.
  - Push into RX when s_valid & s_ready.
  - Pop from TX when m_valid & m_ready.
- rxf_n and txe_n are registered from next-cycle occupancy, so they never permit an over-read or over-write.
  - rxf_n = 1 when RX will be empty.
  - txe_n = 1 when TX will be full.
- Read FSM:
  - R_IDLE -> R_OE when oe_n=0 & rxf_n=0.
  - R_OE -> R_DATA when rd_n=0.
  - R_OE/R_DATA -> R_IDLE when oe_n=1.
- Bus drive: data_oe is registered, 1 one cycle after oe_n sampled low, and 0 one cycle after oe_n sampled high.
- FPGA read pop: when state is R_OE or R_DATA, rd_n=0, oe_n=0, rxf_n=0.
  - data_o advances to the next head the following cycle.
  - cnt_rd increments.
- rd_n=0 in R_IDLE sets err[0]; no pop occurs.
- FPGA write push: when wr_n=0 & txe_n=0, capture {be_i, data_i}; cnt_wr increments.
- wr_n=0 with txe_n=1 sets err[1]; data is dropped.
- oe_n=0 & wr_n=0 sets err[2]; the write is still accepted if txe_n=0.
- Simultaneous events:
  - Same-cycle host push and FPGA pop on RX: occupancy unchanged.
  - Same-cycle FPGA push and host pop on TX: occupancy unchanged.
  - Push into a 1-entry-free FIFO with a simultaneous pop is accepted.
- Pointers are RX/TX_DEPTH_LOG2+1 bits; full and empty are distinguished by the MSB, and wrap is natural.
- ft601_be_o is constant 4'hF.

Optional Feature:
- PCILEECH_FT601_EMU_THROTTLE_EN defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11), seeded by THROTTLE_SEED, steps every cycle.
  - When lfsr[1:0]==2'b00, rxf_n and txe_n are forced to 1 for that cycle, in addition to the occupancy rule.
  - This emulates FT601 chunk gaps; the pop and push conditions use the forced values.
- Undefined: no LFSR logic; flags depend only on occupancy.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with strobes low -> rxf_n=1, txe_n=1, data_oe=0, err=0, cnt_rd=cnt_wr=0.
- Read burst: host pushes 8 words 0x1000..0x1007.
  - Stimulus: FPGA sets oe_n=0, then rd_n=0 for 8 cycles.
  - Response: data_o sequence 0x1000..0x1007, rxf_n=1 the cycle after the 8th pop, cnt_rd=8.
- Write to full, RX_DEPTH_LOG2=TX_DEPTH_LOG2=4, m_ready=0: FPGA writes 20 words.
  - Exactly 16 accepted; txe_n=1 after the 16th; err[1]=1 only if wr_n stays low past txe_n; cnt_wr=16.
  - m_dout then drains 16 words in order with be.
- Protocol error: rd_n=0 with oe_n=1 in R_IDLE -> err=3'b001, no pop, RX contents unchanged.
- Simultaneous and wrap: TX at 15/16 with FPGA push and host pop in the same cycle.
  - Occupancy stays 15.
  - Over 100 cycles of streaming, pointers wrap with no data loss; 100 words compared.
- THROTTLE_EN, seed 16'hACE1: 1000-cycle loopback -> rxf_n forced high on every cycle where lfsr[1:0]==0, zero data loss, err=0.
